// File: rtl/if_stage_fq_pkg.sv
// rtl/if_stage_fq_pkg.sv - shared constants for the instruction-fetch stage and its queue
package if_stage_fq_pkg;

    typedef logic [31:0] word_t;

    localparam word_t    NOP_INST            = 32'h0000_0033;
    localparam logic [4:0] EXC_INST_MISALIGNED = 5'd0;

    // IF/ID bus layout: {inst, pc}
    localparam int IF_ID_W        = 64;
    localparam int IF_ID_PC_LSB   = 0;
    localparam int IF_ID_INST_LSB = 32;

    // exe_if_jmp_bus layout: {jmp_flag, jmp_target[31:0], br_flag}
    localparam int JMP_BUS_W    = 34;
    localparam int JMP_BR_BIT   = 0;
    localparam int JMP_TGT_LSB  = 1;
    localparam int JMP_FLAG_BIT = 33;

    function automatic logic pc_misaligned(input word_t pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_fq_if.sv
// rtl/if_stage_fq_if.sv - imem request/response and fetch-to-decode handshake bundle
interface if_stage_fq_if #(
    parameter int EXC_W = 6
);
    import if_stage_fq_pkg::*;

    word_t               imem_addr;
    logic                imem_req;
    word_t               inst_in;
    logic                fs_to_ds_valid;
    logic                ds_allowin;
    logic [IF_ID_W-1:0]  if_id_bus_out;
    logic [EXC_W-1:0]    exception_code_fd;

    modport master (
        output imem_addr, imem_req, fs_to_ds_valid, if_id_bus_out, exception_code_fd,
        input  inst_in, ds_allowin
    );

    modport slave (
        input  imem_addr, imem_req, fs_to_ds_valid, if_id_bus_out, exception_code_fd,
        output inst_in, ds_allowin
    );

endinterface

// File: rtl/if_stage_fq_fetch_queue.sv
// rtl/if_stage_fq_fetch_queue.sv - generic synchronous FIFO with flush
module fetch_queue #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    last_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign last_ptr = rd_ptr - AW'(1);

    // When empty, show the most recently dequeued slot so the output holds its last value
    assign rdata = empty ? mem[last_ptr] : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_stage_fq.sv
// rtl/if_stage_fq.sv - fetch stage: PC/redirect/credit control feeding a decoupling fetch queue
module if_stage_fq
    import if_stage_fq_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    FQ_DEPTH = 4,
    parameter int    EXC_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_stage_fq_if.master        fs,
    input  logic [JMP_BUS_W-1:0] exe_if_jmp_bus,
    input  logic                 ecall_flag,
    input  logic                 mret_flag,
    input  logic                 exception_flag,
    input  word_t                csr_ecall,
    input  word_t                csr_mret,
    input  logic                 stall_flag
);

    localparam int AW      = $clog2(FQ_DEPTH);
    localparam int ENTRY_W = EXC_W + IF_ID_W;
    localparam logic [EXC_W-1:0] EXC_MISALIGNED = {1'b1, (EXC_W-1)'(EXC_INST_MISALIGNED)};

    word_t        fetch_pc;
    word_t        inflight_pc;
    logic         inflight;
    logic         inflight_exc;
    logic         halted;

    logic         redirect_req;
    logic         redirect;
    word_t        redirect_pc;
    word_t        issue_pc;
    logic         take;
    logic         misaligned;
    logic         credit_ok;
    logic [AW:0]  credits_used;

    logic [ENTRY_W-1:0] fq_wdata;
    logic [ENTRY_W-1:0] fq_rdata;
    logic               fq_push;
    logic               fq_pop;
    logic               fq_full;
    logic               fq_empty;
    logic [AW:0]        fq_count;

    always_comb begin
        redirect_req = 1'b0;
        redirect_pc  = fetch_pc;
        if (exe_if_jmp_bus[JMP_FLAG_BIT] || exe_if_jmp_bus[JMP_BR_BIT]) begin
            redirect_req = 1'b1;
            redirect_pc  = exe_if_jmp_bus[JMP_TGT_LSB +: 32];
        end else if (ecall_flag) begin
            redirect_req = 1'b1;
            redirect_pc  = csr_ecall;
        end else if (mret_flag && exception_flag) begin
            redirect_req = 1'b1;
            redirect_pc  = csr_mret;
        end
    end

    assign redirect = rst_n && redirect_req;
    assign issue_pc = redirect ? redirect_pc : fetch_pc;

    // One credit per queue slot; the outstanding imem response holds one as well
    assign credits_used = fq_count + {{AW{1'b0}}, inflight};
    assign credit_ok    = credits_used < (AW+1)'(FQ_DEPTH);

    // A misaligned PC is "taken" without touching imem so its exception entry still gets a slot
    assign take       = redirect || (rst_n && !stall_flag && !halted && credit_ok);
    assign misaligned = pc_misaligned(issue_pc);

    assign fs.imem_addr = issue_pc;
    assign fs.imem_req  = take && !misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_exc <= 1'b0;
            halted       <= 1'b0;
        end else begin
            inflight <= take;
            if (take) begin
                inflight_pc  <= issue_pc;
                inflight_exc <= misaligned;
                halted       <= misaligned;
                fetch_pc     <= misaligned ? issue_pc : issue_pc + 32'd4;
            end
        end
    end

    always_comb begin
        fq_wdata = '0;
        fq_wdata[IF_ID_PC_LSB +: 32]   = inflight_pc;
        fq_wdata[IF_ID_INST_LSB +: 32] = inflight_exc ? NOP_INST : fs.inst_in;
        fq_wdata[IF_ID_W +: EXC_W]     = inflight_exc ? EXC_MISALIGNED : '0;
    end

    // The flush wins over the push, which is what drops the stale response in a redirect cycle
    assign fq_push = inflight;
    assign fq_pop  = fs.fs_to_ds_valid && fs.ds_allowin;

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fq_push),
        .pop   (fq_pop),
        .flush (redirect),
        .wdata (fq_wdata),
        .rdata (fq_rdata),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count)
    );

    assign fs.fs_to_ds_valid    = !fq_empty && !redirect;
    assign fs.if_id_bus_out     = fq_rdata[IF_ID_W-1:0];
    assign fs.exception_code_fd = fq_rdata[ENTRY_W-1:IF_ID_W];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fq_push && !redirect && fq_full && !fq_pop));

endmodule

// File: tb/tb_if_stage_fq.sv
// tb/tb_if_stage_fq.sv - scoreboard bench for the fetch stage with queue
module tb_if_stage_fq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] jmp_bus = '0;
    logic        ecall_flag = 1'b0;
    logic        mret_flag = 1'b0;
    logic        exception_flag = 1'b0;
    logic        stall_flag = 1'b0;
    logic [31:0] csr_ecall = 32'h80;
    logic [31:0] csr_mret = 32'h44;

    int checks = 0;
    int failures = 0;
    logic [69:0] exp_q[$];
    logic [69:0] exp_e;

    if_stage_fq_if #(.EXC_W(6)) bus_if ();

    if_stage_fq #(
        .RESET_PC (32'h0),
        .FQ_DEPTH (4),
        .EXC_W    (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fs             (bus_if),
        .exe_if_jmp_bus (jmp_bus),
        .ecall_flag     (ecall_flag),
        .mret_flag      (mret_flag),
        .exception_flag (exception_flag),
        .csr_ecall      (csr_ecall),
        .csr_mret       (csr_mret),
        .stall_flag     (stall_flag)
    );

    always #5 clk = ~clk;

    // imem model: 1-cycle latency, returns the address as data
    always @(posedge clk)
        bus_if.inst_in <= bus_if.imem_req ? bus_if.imem_addr : 32'hdead_beef;

    // Scoreboard: every transfer to decode must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && bus_if.fs_to_ds_valid && bus_if.ds_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h required=none", {bus_if.exception_code_fd, bus_if.if_id_bus_out});
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus_if.exception_code_fd, bus_if.if_id_bus_out} !== exp_e) begin
                    failures++;
                    $display("FAIL sb_entry got=%h required=%h", {bus_if.exception_code_fd, bus_if.if_id_bus_out}, exp_e);
                end
            end
        end
    end

    function automatic logic [69:0] ent(input logic [5:0] exc, input logic [31:0] inst, input logic [31:0] pc);
        return {exc, inst, pc};
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        jmp_bus = '0;
        ecall_flag = 1'b0;
        mret_flag = 1'b0;
        exception_flag = 1'b0;
        stall_flag = 1'b0;
        bus_if.ds_allowin = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_if.ds_allowin = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.imem_addr !== 32'h0 || bus_if.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_imem addr=%h req=%b required addr=00000000 req=0", bus_if.imem_addr, bus_if.imem_req);
        end
        checks++;
        if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.if_id_bus_out !== 64'h0 || bus_if.exception_code_fd !== 6'h0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b bus=%h exc=%h required 0", bus_if.fs_to_ds_valid, bus_if.if_id_bus_out, bus_if.exception_code_fd);
        end
    endtask

    task automatic test_stream;
        do_reset();
        bus_if.ds_allowin = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(ent(6'h0, 32'(4*k), 32'(4*k)));
            @(negedge clk);
            checks++;
            if (bus_if.imem_addr !== 32'(4*k) || bus_if.imem_req !== 1'b1) begin
                failures++;
                $display("FAIL stream_issue cyc=%0d addr=%h req=%b required addr=%h req=1", k, bus_if.imem_addr, bus_if.imem_req, 32'(4*k));
            end
            checks++;
            if (bus_if.fs_to_ds_valid !== 1'(k >= 2)) begin
                failures++;
                $display("FAIL stream_valid cyc=%0d got=%b required=%b", k, bus_if.fs_to_ds_valid, 1'(k >= 2));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 2) begin
            failures++;
            $display("FAIL stream_outstanding got=%0d required=2", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic        req_e;
        logic [31:0] addr_e;
        do_reset();
        for (int i = 0; i < 7; i++) exp_q.push_back(ent(6'h0, 32'(4*i), 32'(4*i)));
        for (int k = 0; k < 17; k++) begin
            bus_if.ds_allowin = (k >= 10);
            req_e  = (k <= 3) || (k >= 11);
            addr_e = (k <= 3) ? 32'(4*k) : (k <= 10) ? 32'd16 : 32'(16 + 4*(k-11));
            @(negedge clk);
            checks++;
            if (bus_if.imem_req !== req_e || bus_if.imem_addr !== addr_e) begin
                failures++;
                $display("FAIL bp_issue cyc=%0d req=%b addr=%h required req=%b addr=%h", k, bus_if.imem_req, bus_if.imem_addr, req_e, addr_e);
            end
            if (k == 9) begin
                checks++;
                if (bus_if.fs_to_ds_valid !== 1'b1 || bus_if.if_id_bus_out !== 64'h0) begin
                    failures++;
                    $display("FAIL bp_head valid=%b bus=%h required valid=1 bus=0", bus_if.fs_to_ds_valid, bus_if.if_id_bus_out);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_flush_full;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bus_if.ds_allowin = (k >= 5);
            jmp_bus = (k == 4) ? {1'b0, 32'h100, 1'b1} : 34'h0;
            if (k == 4) for (int i = 0; i < 3; i++) exp_q.push_back(ent(6'h0, 32'h100 + 32'(4*i), 32'h100 + 32'(4*i)));
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (bus_if.imem_addr !== 32'h100 || bus_if.imem_req !== 1'b1 || bus_if.fs_to_ds_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_redirect addr=%h req=%b valid=%b required 00000100 1 0", bus_if.imem_addr, bus_if.imem_req, bus_if.fs_to_ds_valid);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.imem_addr !== 32'h104) begin
                    failures++;
                    $display("FAIL flush_stale valid=%b addr=%h required 0 00000104", bus_if.fs_to_ds_valid, bus_if.imem_addr);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL flush_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_redirect(input string name, input logic [33:0] jb, input logic ec,
                                 input logic mr, input logic ef, input logic redir, input logic [31:0] target);
        logic [31:0] addr_e;
        do_reset();
        bus_if.ds_allowin = 1'b1;
        exp_q.push_back(ent(6'h0, 32'h0, 32'h0));
        if (!redir) for (int i = 1; i < 5; i++) exp_q.push_back(ent(6'h0, 32'(4*i), 32'(4*i)));
        addr_e = redir ? target : 32'd12;
        for (int k = 0; k < 7; k++) begin
            jmp_bus        = (k == 3) ? jb : 34'h0;
            ecall_flag     = (k == 3) && ec;
            mret_flag      = (k == 3) && mr;
            exception_flag = (k == 3) && ef;
            if (k == 3 && redir) begin
                exp_q.push_back(ent(6'h0, target, target));
                exp_q.push_back(ent(6'h0, target + 32'd4, target + 32'd4));
            end
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if (bus_if.imem_addr !== addr_e || bus_if.imem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_addr addr=%h req=%b required addr=%h req=1", name, bus_if.imem_addr, bus_if.imem_req, addr_e);
                end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (bus_if.fs_to_ds_valid !== !redir) begin
                    failures++;
                    $display("FAIL %s_valid cyc=%0d got=%b required=%b", name, k, bus_if.fs_to_ds_valid, !redir);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_misaligned;
        do_reset();
        bus_if.ds_allowin = 1'b1;
        exp_q.push_back(ent(6'h0, 32'h0, 32'h0));
        for (int k = 0; k < 14; k++) begin
            jmp_bus = (k == 3) ? {1'b1, 32'h102, 1'b0} : (k == 11) ? {1'b0, 32'h200, 1'b1} : 34'h0;
            if (k == 3)  exp_q.push_back(ent(6'b100000, 32'h0000_0033, 32'h102));
            if (k == 11) exp_q.push_back(ent(6'h0, 32'h200, 32'h200));
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if (bus_if.imem_addr !== 32'h102 || bus_if.imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL mis_issue addr=%h req=%b required addr=00000102 req=0", bus_if.imem_addr, bus_if.imem_req);
                end
            end
            if (k >= 4 && k <= 10) begin
                checks++;
                if (bus_if.imem_req !== 1'b0 || bus_if.fs_to_ds_valid !== 1'(k == 5)) begin
                    failures++;
                    $display("FAIL mis_halt cyc=%0d req=%b valid=%b required req=0 valid=%b", k, bus_if.imem_req, bus_if.fs_to_ds_valid, 1'(k == 5));
                end
            end
            if (k == 11) begin
                checks++;
                if (bus_if.imem_addr !== 32'h200 || bus_if.imem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL mis_resume addr=%h req=%b required addr=00000200 req=1", bus_if.imem_addr, bus_if.imem_req);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mis_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        bus_if.ds_allowin = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(6'h0, 32'(4*i), 32'(4*i)));
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.imem_addr !== 32'h0 || bus_if.imem_req !== 1'b0 || bus_if.fs_to_ds_valid !== 1'b0 ||
            bus_if.if_id_bus_out !== 64'h0 || bus_if.exception_code_fd !== 6'h0) begin
            failures++;
            $display("FAIL areset_outputs addr=%h req=%b valid=%b bus=%h exc=%h required 00000000 0 0 0 0",
                     bus_if.imem_addr, bus_if.imem_req, bus_if.fs_to_ds_valid, bus_if.if_id_bus_out, bus_if.exception_code_fd);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(ent(6'h0, 32'h0, 32'h0));
        exp_q.push_back(ent(6'h0, 32'h4, 32'h4));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (bus_if.imem_addr !== 32'h0 || bus_if.imem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL areset_restart addr=%h req=%b required addr=00000000 req=1", bus_if.imem_addr, bus_if.imem_req);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL areset_drain left=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_redirect("br_ecall", {1'b0, 32'h100, 1'b1}, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        test_redirect("ecall", 34'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        test_redirect("mret_noexc", 34'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        test_redirect("mret_exc", 34'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44);
        test_misaligned();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
